// File: rtl/instruction_fetch.sv
// Single-slot instruction fetch stage: one request in flight, one-cycle accept into the
// decode slot, redirect flush, and a sticky fault on a misaligned redirect target.
//
// state | meaning
// FETCH | normal fetching; requests issued whenever the decode slot can take a word
// FAULT | misaligned redirect seen; fetching halted until reset
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic        fetch_fault
);

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic {FETCH, FAULT} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] instr_next, pc_out_next;
  logic        valid_next, fault_next;

  assign imem_addr = pc;

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    instr_next  = instr_out;
    pc_out_next = pc_out;
    valid_next  = instr_valid;
    fault_next  = fetch_fault;
    imem_req    = 1'b0;
    case (state)
      FETCH: begin
        imem_req = reset_n && !redirect_valid && (!instr_valid || !stall);
        if (redirect_valid) begin
          // Redirect wins over stall and any same-cycle memory data.
          valid_next = 1'b0;
          instr_next = 32'h0000_0000;
          if (redirect_pc[1:0] != 2'b00) begin
            state_next = FAULT;
            fault_next = 1'b1;
          end else begin
            pc_next = redirect_pc;
          end
        end else if (imem_req && imem_ready) begin
          instr_next  = imem_rdata;
          pc_out_next = pc;
          valid_next  = 1'b1;
          pc_next     = pc + 32'd4;
        end else if (instr_valid && !stall) begin
          valid_next = 1'b0;
          instr_next = 32'h0000_0000;
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= FETCH;
      pc          <= RESET_PC_ALIGNED;
      instr_out   <= 32'h0000_0000;
      pc_out      <= 32'h0000_0000;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instr_out   <= instr_next;
      pc_out      <= pc_out_next;
      instr_valid <= valid_next;
      fetch_fault <= fault_next;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed vector bench for instruction_fetch: table of per-cycle inputs with
// expected pre-edge request/address and post-edge slot contents, plus reset and wrap sequences.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  logic        req_a, valid_a, fault_a;
  logic [31:0] addr_a, instr_a, pc_a;
  logic        req_b, valid_b, fault_b;
  logic [31:0] addr_b, instr_b, pc_b;

  int tests  = 0;
  int failed = 0;

  always #5 clock = ~clock;

  instruction_fetch u_dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(req_a), .imem_addr(addr_a), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_out(instr_a), .pc_out(pc_a), .instr_valid(valid_a), .fetch_fault(fault_a)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(req_b), .imem_addr(addr_b), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_out(instr_b), .pc_out(pc_b), .instr_valid(valid_b), .fetch_fault(fault_b)
  );

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        ready;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_fault;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // stall rv rpc ready rdata | req addr | valid instr pc_out fault
    vecs[0]  = '{0, 0, 32'h0,   1, 32'h33,   1, 32'h0,   1, 32'h33, 32'h0,   0};
    vecs[1]  = '{0, 0, 32'h0,   1, 32'h33,   1, 32'h4,   1, 32'h33, 32'h4,   0};
    vecs[2]  = '{0, 0, 32'h0,   1, 32'h33,   1, 32'h8,   1, 32'h33, 32'h8,   0};
    vecs[3]  = '{1, 0, 32'h0,   1, 32'hAA,   0, 32'hC,   1, 32'h33, 32'h8,   0};
    vecs[4]  = '{1, 0, 32'h0,   1, 32'hAA,   0, 32'hC,   1, 32'h33, 32'h8,   0};
    vecs[5]  = '{1, 0, 32'h0,   1, 32'hAA,   0, 32'hC,   1, 32'h33, 32'h8,   0};
    vecs[6]  = '{0, 0, 32'h0,   1, 32'h11,   1, 32'hC,   1, 32'h11, 32'hC,   0};
    vecs[7]  = '{0, 0, 32'h0,   0, 32'hBB,   1, 32'h10,  0, 32'h0,  32'hC,   0};
    vecs[8]  = '{0, 0, 32'h0,   0, 32'hBB,   1, 32'h10,  0, 32'h0,  32'hC,   0};
    vecs[9]  = '{0, 0, 32'h0,   0, 32'hBB,   1, 32'h10,  0, 32'h0,  32'hC,   0};
    vecs[10] = '{0, 0, 32'h0,   0, 32'hBB,   1, 32'h10,  0, 32'h0,  32'hC,   0};
    vecs[11] = '{0, 0, 32'h0,   1, 32'h22,   1, 32'h10,  1, 32'h22, 32'h10,  0};
    vecs[12] = '{0, 1, 32'h100, 1, 32'hDEAD, 0, 32'h14,  0, 32'h0,  32'h10,  0};
    vecs[13] = '{0, 0, 32'h0,   1, 32'h44,   1, 32'h100, 1, 32'h44, 32'h100, 0};
    vecs[14] = '{1, 0, 32'h0,   1, 32'h55,   0, 32'h104, 1, 32'h44, 32'h100, 0};
    vecs[15] = '{1, 1, 32'h200, 1, 32'h55,   0, 32'h104, 0, 32'h0,  32'h100, 0};
    vecs[16] = '{1, 0, 32'h0,   1, 32'h66,   1, 32'h200, 1, 32'h66, 32'h200, 0};
    vecs[17] = '{0, 1, 32'h102, 1, 32'h77,   0, 32'h204, 0, 32'h0,  32'h200, 1};
    vecs[18] = '{0, 1, 32'h300, 1, 32'h88,   0, 32'h204, 0, 32'h0,  32'h200, 1};
    vecs[19] = '{0, 0, 32'h0,   1, 32'h99,   0, 32'h204, 0, 32'h0,  32'h200, 1};

    reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_ready = 1'b0; imem_rdata = '0;
    tick();
    tick();
    check("reset req", {31'b0, req_a}, 32'h0);
    check("reset valid", {31'b0, valid_a}, 32'h0);
    check("reset fault", {31'b0, fault_a}, 32'h0);
    check("reset instr", instr_a, 32'h0);
    check("reset pc_out", pc_a, 32'h0);
    check("reset addr", addr_a, 32'h0);

    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      stall = vecs[i].stall; redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
      imem_ready = vecs[i].ready; imem_rdata = vecs[i].rdata;
      #1;
      check($sformatf("v%0d req", i), {31'b0, req_a}, {31'b0, vecs[i].e_req});
      check($sformatf("v%0d addr", i), addr_a, vecs[i].e_addr);
      tick();
      check($sformatf("v%0d valid", i), {31'b0, valid_a}, {31'b0, vecs[i].e_valid});
      check($sformatf("v%0d instr", i), instr_a, vecs[i].e_instr);
      check($sformatf("v%0d pc_out", i), pc_a, vecs[i].e_pc);
      check($sformatf("v%0d fault", i), {31'b0, fault_a}, {31'b0, vecs[i].e_fault});
    end

    // Reset beats a pending redirect and ready memory while in FAULT.
    reset_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h400;
    imem_ready = 1'b1; imem_rdata = 32'hBAD;
    #1;
    check("rst req low", {31'b0, req_a}, 32'h0);
    tick();
    check("rst fault clr", {31'b0, fault_a}, 32'h0);
    check("rst valid clr", {31'b0, valid_a}, 32'h0);
    check("rst addr", addr_a, 32'h0);

    // First cycle out of reset requests immediately; wrap instance crosses 2^32.
    reset_n = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_rdata = 32'h77;
    #1;
    check("post-rst req", {31'b0, req_a}, 32'h1);
    check("post-rst addr", addr_a, 32'h0);
    check("wrap req", {31'b0, req_b}, 32'h1);
    check("wrap addr0", addr_b, 32'hFFFF_FFFC);
    tick();
    check("wrap pc_out0", pc_b, 32'hFFFF_FFFC);
    check("wrap instr0", instr_b, 32'h77);
    check("wrap addr1", addr_b, 32'h0);
    imem_rdata = 32'h78;
    tick();
    check("wrap pc_out1", pc_b, 32'h0);
    check("wrap instr1", instr_b, 32'h78);
    check("wrap valid1", {31'b0, valid_b}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
